// File: rtl/display_pkg.sv
// Shared types and constants for the HEX0 display arbiter.
package display_pkg;

  // Arbiter phases: waiting for a request, driving the display, and the one-cycle
  // blank handover between owners.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } disp_state_t;

  // Segment order is g..a, active-low: a 0 bit lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex glyphs 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_display_arbiter_hex7seg.sv
// Combinational 4-bit hex value to active-low 7-segment decoder.
module hex7seg (
  input  logic [3:0] value,
  output logic [6:0] seg
);
  import display_pkg::*;

  // Pure table lookup; the caller registers the result.
  always_comb begin
    seg = SEG_TABLE[value];
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner selection for the single HEX0 display. The owner keeps the
// display for at most HOLD_CYCLES cycles while someone else waits, every handover
// passes through one blank GAP cycle, and all outputs come straight from flops.
// dbg_state mirrors the FSM state register for observation.
module hex_display_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] digit,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [6:0]        HEX0,
  output logic [1:0]        dbg_state
);
  import display_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RESET = IW'(NREQ - 1);

  // Search starts one past the previous owner and wraps modulo NREQ (which need
  // not be a power of two). Doubling the request vector turns the wrap into a
  // plain right shift; the lowest set bit of the rotated vector wins, and the
  // rotation offset is added back to recover the real index.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   last);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                start;
    int                idx;
    int                p;
    start = int'(last) + 1;
    if (start >= NREQ) start = 0;
    dbl = {r, r} >> start;
    rot = dbl[NREQ-1:0];
    idx = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = i;
    end
    p = start + idx;
    if (p >= NREQ) p = p - NREQ;
    return IW'(p);
  endfunction

  disp_state_t     state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [6:0]      hex_q, hex_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   pick;
  logic [3:0]      owner_digit;
  logic [6:0]      owner_seg;

  // Next owner candidate; only consumed in IDLE.
  always_comb begin
    pick = rr_pick(req, last_q);
  end

  // The current owner is always last_q while in SHOW; the digit stays live.
  always_comb begin
    owner_digit = 4'h0;
    for (int i = 0; i < NREQ; i++) begin
      if (last_q == IW'(i)) owner_digit = digit[4*i +: 4];
    end
  end

  hex7seg u_hex7seg (
    .value (owner_digit),
    .seg   (owner_seg)
  );

  // Next-state logic: HEX0 shows the owner's glyph only while SHOW continues,
  // so the first SHOW cycle and the GAP cycle are both blank.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    hold_d  = hold_q;
    hex_d   = SEG_BLANK;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        hold_d  = '0;
        if (req != '0) begin
          state_d = SHOW;
          last_d  = pick;
          grant_d = NREQ'(1) << pick;
        end
      end
      SHOW: begin
        hold_d = hold_q + CW'(1);
        hex_d  = owner_seg;
        if ((req & grant_q) == '0) begin
          // Owner let go; this also covers a drop coinciding with hold expiry.
          state_d = GAP;
          grant_d = '0;
          hold_d  = '0;
          hex_d   = SEG_BLANK;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if ((req & ~grant_q) != '0) begin
            state_d = GAP;
            grant_d = '0;
            hex_d   = SEG_BLANK;
          end
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // busy is registered from the next state so it lines up with grant.
  always_comb begin
    busy_d = (state_d == SHOW);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RESET;
      hold_q  <= '0;
      hex_q   <= SEG_BLANK;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      hex_q   <= hex_d;
      busy_q  <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign HEX0      = hex_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with NREQ=4, HOLD_CYCLES=8.
module tb_hex_display_arbiter;
  import display_pkg::*;

  localparam int NREQ = 4;
  localparam int HOLD = 8;

  logic        CLOCK_50;
  logic        Reset;
  logic [3:0]  req;
  logic [15:0] digit;
  logic [3:0]  grant;
  logic        busy;
  logic [6:0]  HEX0;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [3:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

  hex_display_arbiter #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .req       (req),
    .digit     (digit),
    .grant     (grant),
    .busy      (busy),
    .HEX0      (HEX0),
    .dbg_state (dbg_state)
  );

  // Clock
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance one edge and settle before sampling/driving.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic b,
                           input logic [6:0] h, input logic [1:0] s);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".hex0"},  32'(HEX0),  32'(h));
    check({tag, ".state"}, 32'(dbg_state), 32'(s));
  endtask

  initial begin
    Reset = 1'b1;
    req   = 4'hF;
    digit = 16'h0500;

    // Reset held two cycles with every requester active.
    step();
    check_out("rst_c1", 4'b0000, 1'b0, 7'h7F, IDLE);
    step();
    check_out("rst_c2", 4'b0000, 1'b0, 7'h7F, IDLE);
    Reset = 1'b0;

    // First pick after reset starts from requester 0.
    step();
    check_out("first_grant", 4'b0001, 1'b1, 7'h7F, SHOW);
    req = 4'b0000;

    // Owner 0 releases: one GAP cycle.
    step();
    check_out("rel0_gap", 4'b0000, 1'b0, 7'h7F, GAP);
    req = 4'b0100;

    // Request arriving during GAP is acted on from IDLE.
    step();
    check_out("gap_idle", 4'b0000, 1'b0, 7'h7F, IDLE);
    step();
    check_out("grant2", 4'b0100, 1'b1, 7'h7F, SHOW);
    step();
    check_out("hex5", 4'b0100, 1'b1, 7'h12, SHOW);

    // Lone requester keeps the display past the hold limit.
    for (int i = 0; i < 11; i++) begin
      step();
      check_out("hold_alone", 4'b0100, 1'b1, 7'h12, SHOW);
    end

    // Reset while owner 2 is at hold count 4.
    Reset = 1'b1;
    req   = 4'b1011;
    step();
    check_out("rst_mid", 4'b0000, 1'b0, 7'h7F, IDLE);
    Reset = 1'b0;
    step();

    // Constant req=1011: round-robin order, 8-cycle grants, GAP then IDLE between.
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < HOLD; c++) begin
        check_out("rr_show", rr_exp[k], 1'b1, (c == 0) ? 7'h7F : 7'h40, SHOW);
        step();
      end
      check_out("rr_gap", 4'b0000, 1'b0, 7'h7F, GAP);
      step();
      check_out("rr_idle", 4'b0000, 1'b0, 7'h7F, IDLE);
      step();
    end
    check_out("rr_wrap", rr_exp[3], 1'b1, 7'h7F, SHOW);

    // Owner 0 releases; requester 1 is next.
    req = 4'b1010;
    step();
    check_out("rel0b_gap", 4'b0000, 1'b0, 7'h7F, GAP);
    step();
    check_out("rel0b_idle", 4'b0000, 1'b0, 7'h7F, IDLE);
    step();
    check_out("own1_c1", 4'b0010, 1'b1, 7'h7F, SHOW);
    digit = 16'hA500;
    step();
    check_out("own1_c2", 4'b0010, 1'b1, 7'h40, SHOW);
    step();
    check_out("own1_c3", 4'b0010, 1'b1, 7'h40, SHOW);

    // Owner 1 drops after 3 cycles with requester 3 waiting: no hold wait.
    req = 4'b1000;
    step();
    check_out("drop1_gap", 4'b0000, 1'b0, 7'h7F, GAP);
    step();
    check_out("drop1_idle", 4'b0000, 1'b0, 7'h7F, IDLE);
    step();
    check_out("own3_c1", 4'b1000, 1'b1, 7'h7F, SHOW);
    step();
    check_out("own3_hexA", 4'b1000, 1'b1, 7'h08, SHOW);

    // Live digit change mid-SHOW.
    digit = 16'hD500;
    step();
    check_out("own3_hexd", 4'b1000, 1'b1, 7'h21, SHOW);
    step();
    check_out("own3_hold", 4'b1000, 1'b1, 7'h21, SHOW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
